// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first.
// Ports: clk, rst (sync, active-high), start/a/b in; busy/done/diff/borrow/ovf out.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sb_q;
    logic [WIDTH-1:0] dsh_q, dsh_d;
    logic [CW-1:0]    cnt_q;
    logic             bff_q;
    logic             amsb_q, bmsb_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q, ovf_q;

    logic             bit_d, bit_bo, last;

    // Full-subtractor bit slice on the current LSBs plus the registered borrow.
    always_comb begin
        bit_d  = sa_q[0] ^ sb_q[0] ^ bff_q;
        bit_bo = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & bff_q);
        last   = (cnt_q == CW'(WIDTH - 1));
        dsh_d  = {bit_d, dsh_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa_q     <= '0;
            sb_q     <= '0;
            dsh_q    <= '0;
            cnt_q    <= '0;
            bff_q    <= 1'b0;
            amsb_q   <= 1'b0;
            bmsb_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        sa_q   <= a;
                        sb_q   <= b;
                        amsb_q <= a[WIDTH-1];
                        bmsb_q <= b[WIDTH-1];
                        bff_q  <= 1'b0;
                        cnt_q  <= '0;
                    end
                end
                SHIFT: begin
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    dsh_q <= dsh_d;
                    bff_q <= bit_bo;
                    cnt_q <= cnt_q + CW'(1);
                    // Visible results change only here, as DONE is entered;
                    // the last serial bit is the result MSB.
                    if (last) begin
                        diff_q   <= dsh_d;
                        borrow_q <= bit_bo;
                        ovf_q    <= (amsb_q != bmsb_q) && (bit_d != amsb_q);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state_q == SHIFT);
    assign done   = (state_q == DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8).
// Directed cases, abort-by-reset, and back-to-back random vectors vs a model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, borrow, ovf;
    logic [W-1:0] diff;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] last_diff;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input logic [31:0] obs, input logic [31:0] exp,
                         input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on integers.
    function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        int sx, sy, s;
        logic [W-1:0] r;
        logic bo, ov;
        r  = x - y;
        bo = (int'(x) < int'(y));
        sx = int'($signed(x));
        sy = int'($signed(y));
        s  = sx - sy;
        ov = (s > 127) || (s < -128);
        return {bo, ov, r};
    endfunction

    // One operation from IDLE. glitch_at > 0 raises start inside SHIFT.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic [W-1:0] ed, input logic eb,
                         input logic eo, input int glitch_at,
                         input string tag);
        int n;
        logic hold_bad;
        hold_bad = 1'b0;
        @(negedge clk);
        a = ta; b = tb_; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        n = 1;
        while (done !== 1'b1 && n < 20) begin
            if (busy !== 1'b1 || diff !== last_diff) hold_bad = 1'b1;
            if (n == glitch_at) begin
                start = 1'b1; a = 8'($urandom); b = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        // done appears WIDTH edges after the accepting edge.
        check(n, W + 1, {tag, "_latency"});
        check(32'(hold_bad), 0, {tag, "_hold"});
        check(32'(diff), 32'(ed), {tag, "_diff"});
        check(32'(borrow), 32'(eb), {tag, "_borrow"});
        check(32'(ovf), 32'(eo), {tag, "_ovf"});
        last_diff = ed;
        @(negedge clk);
        check(32'({done, busy}), 0, {tag, "_after"});
    endtask

    initial begin
        logic [W+1:0] m;
        int n;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        last_diff = '0;
        repeat (3) @(negedge clk);
        check(32'({busy, done, borrow, ovf}), 0, "reset_flags");
        check(32'(diff), 0, "reset_diff");
        rst = 1'b0;

        do_op(8'd5, 8'd3, 8'h02, 1'b0, 1'b0, 0, "t1");
        do_op(8'd3, 8'd5, 8'hFE, 1'b1, 1'b0, 0, "t2a");
        do_op(8'd0, 8'd0, 8'h00, 1'b0, 1'b0, 0, "t2b");
        do_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 0, "t3a");
        do_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 0, "t3b");
        do_op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 3, "t4_ignore");

        // Reset in the middle of SHIFT abandons the operation.
        @(negedge clk);
        a = 8'h55; b = 8'h11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check(32'(busy), 1, "t5_busy_pre");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check(32'({busy, done, borrow, ovf}), 0, "t5_flags");
        check(32'(diff), 0, "t5_diff");
        last_diff = '0;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
        check(n, 0, "t5_no_done");
        do_op(8'h55, 8'h11, 8'h44, 1'b0, 1'b0, 0, "t5_after");

        // Back-to-back with start held high: one accept every WIDTH+2 cycles.
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] xa, xb;
            xa = 8'($urandom); xb = 8'($urandom);
            if (i % 16 == 0) begin xa = 8'h80; xb = 8'($urandom_range(0, 3)); end
            a = xa; b = xb;
            m = model(xa, xb);
            @(negedge clk);
            a = 8'($urandom); b = 8'($urandom);
            n = 1;
            while (done !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check(n, W + 1, "b2b_latency");
            check(32'({borrow, ovf, diff}), 32'(m), "b2b_result");
            @(negedge clk);
            check(32'({done, busy}), 0, "b2b_idle");
        end
        start = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
